// File: rtl/uart_pkg.sv
// Shared constants for the buffered 8N1 UART transmitter.
// Holds the FSM encoding, default sizing and frame format.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } tx_state_e;

    localparam int DIV_DEFAULT   = 104;
    localparam int DEPTH_DEFAULT = 4;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with registered full/empty flags.
// Read data is the head entry; no write-to-read bypass.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = DATA_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW+1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    // Flags come from the next pointers so they are valid right after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= (wptr_d[AW] != rptr_d[AW]) &&
                       (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
            empty_q <= (wptr_d == rptr_d);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: ack handshake, FIFO, baud counter
// and a registered TX FSM that streams frames back to back.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_valid,
    input  logic [7:0] uart_data,
    output logic       uart_ack,
    output logic       tx,
    output logic       busy
);

    localparam int            CW        = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ack_q, busy_q;
    logic          push, pop, full, empty, tick;
    logic [7:0]    rdata;

    // The ~ack_q term keeps the byte still held in the ack cycle from being taken twice.
    assign push = uart_valid & ~ack_q & ~full;
    assign tick = (cnt_q == CNT_MAX);

    uart_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (uart_data),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = rdata;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (idx_q != STOP_LAST) begin
                        idx_d = idx_q + 3'd1;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        shift_d = rdata;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The pin level is derived from the next state so it changes with the state register.
    always_comb begin
        tx_d = 1'b1;
        if (state_d == START)     tx_d = 1'b0;
        else if (state_d == DATA) tx_d = shift_d[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ack_q   <= push;
            busy_q  <= (state_q != IDLE) | ~empty;
        end
    end

    assign uart_ack = ack_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: streamer-style producer, serial frame monitor
// and a byte-order scoreboard, plus a DIV=2 waveform check.
module tb_uart_tx_buf;

    localparam int TDIV   = 4;
    localparam int TDEPTH = 4;
    localparam int FR     = 10 * TDIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       uart_valid = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       uart_ack, tx, busy;
    logic       v2 = 1'b0;
    logic [7:0] d2 = 8'h00;
    logic       ack2, tx2, busy2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] exp_q[$];
    int         ack_q[$];
    int         start_q[$];

    bit         mon_act = 1'b0;
    int         mon_n = 0;
    int         mon_bad = 0;
    int         mon_frames = 0;
    logic [7:0] mon_byte = 8'h00;

    uart_tx_buf #(.DIV(TDIV), .DEPTH(TDEPTH)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_valid (uart_valid),
        .uart_data  (uart_data),
        .uart_ack   (uart_ack),
        .tx         (tx),
        .busy       (busy)
    );

    uart_tx_buf #(.DIV(2), .DEPTH(TDEPTH)) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_valid (v2),
        .uart_data  (d2),
        .uart_ack   (ack2),
        .tx         (tx2),
        .busy       (busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 8N1 frame: start 0, data LSB first, stop 1.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Serial monitor: every frame is checked cycle by cycle against the next queued byte.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
        end else begin
            if (!mon_act && tx === 1'b0) begin
                mon_act = 1'b1;
                mon_n   = 0;
                mon_bad = 0;
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    mon_bad  = 1;
                    mon_byte = 8'h00;
                end else begin
                    mon_byte = exp_q.pop_front();
                end
            end
            if (mon_act) begin
                if (tx !== frame_bit(mon_byte, mon_n / TDIV)) mon_bad++;
                mon_n++;
                if (mon_n == FR) begin
                    chk($sformatf("frame_%02h", mon_byte), mon_bad, 0);
                    mon_act = 1'b0;
                    mon_frames++;
                end
            end
            if (uart_ack === 1'b1) ack_q.push_back(cyc);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        uart_valid = 1'b1;
        uart_data  = b;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (uart_ack !== 1'b1 && n < 2000);
        if (uart_ack !== 1'b1) chk("ack_timeout", uart_ack, 1);
        else exp_q.push_back(b);
        @(posedge clk);
        #1;
        uart_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || mon_act || exp_q.size() != 0) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_busy", busy, 0);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: time %0t reached, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int a0, s0, f0, bad, n;
        int exp_gap[7];
        logic w2[44];
        logic e;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_ack", uart_ack, 0);
        rst_n = 1'b1;
        wait_cycles(2);

        // Single byte 0xA5.
        send_byte(8'hA5);
        chk("single_tx_start", tx, 0);
        chk("single_busy_on", busy, 1);
        wait_cycles(39);
        chk("single_last_stop_tx", tx, 1);
        chk("single_last_stop_busy", busy, 1);
        wait_cycles(1);
        chk("single_busy_hold", busy, 1);
        wait_cycles(1);
        chk("single_busy_off", busy, 0);
        chk("single_acks", ack_q.size(), 1);
        chk("single_frames", mon_frames, 1);
        if (ack_q.size() > 0 && start_q.size() > 0)
            chk("single_latency", start_q[0] - ack_q[0], 1);

        // Burst 0x00..0x07 into a 4-deep FIFO.
        a0 = ack_q.size();
        s0 = start_q.size();
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        wait_idle();
        chk("burst_acks", ack_q.size() - a0, 8);
        chk("burst_frames", start_q.size() - s0, 8);
        exp_gap = '{2, 2, 2, 2, FR - 6, FR, FR};
        if (ack_q.size() - a0 == 8) begin
            for (int i = 0; i < 7; i++)
                chk($sformatf("burst_ack_gap%0d", i),
                    ack_q[a0+i+1] - ack_q[a0+i], exp_gap[i]);
        end
        if (start_q.size() - s0 == 8) begin
            chk("burst_latency", start_q[s0] - ack_q[a0], 1);
            bad = 0;
            for (int i = 0; i < 7; i++)
                if (start_q[s0+i+1] - start_q[s0+i] != FR) bad++;
            chk("burst_contiguous", bad, 0);
        end

        // Streamer-style producer: 256 random bytes with random pauses.
        a0 = ack_q.size();
        f0 = mon_frames;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 7) == 0) wait_cycles($urandom_range(1, 60));
            send_byte(8'($urandom));
        end
        wait_idle();
        chk("stream_acks", ack_q.size() - a0, 256);
        chk("stream_frames", mon_frames - f0, 256);

        // Asynchronous reset during data bit 3.
        f0 = mon_frames;
        send_byte(8'hF0);
        wait_cycles(17);
        chk("rst_pre_tx", tx, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_tx", tx, 1);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_ack", uart_ack, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cycles(5);
        chk("rst_after_tx", tx, 1);
        chk("rst_after_busy", busy, 0);
        chk("rst_no_frame", mon_frames - f0, 0);
        send_byte(8'h3C);
        wait_idle();
        chk("rst_next_frame", mon_frames - f0, 1);

        // DIV = 2: 0xFF then 0x00, back to back.
        v2 = 1'b1;
        d2 = 8'hFF;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ack2 !== 1'b1 && n < 100);
        chk("div2_ack", ack2, 1);
        @(posedge clk);
        #1;
        d2 = 8'h00;
        for (int i = 0; i < 44; i++) begin
            w2[i] = tx2;
            if (ack2 === 1'b1) v2 = 1'b0;
            @(posedge clk);
            #1;
        end
        v2 = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            e = frame_bit(8'hFF, i / 2);
            if (w2[i] !== e) bad++;
        end
        chk("div2_ff_frame", bad, 0);
        bad = 0;
        for (int i = 20; i < 40; i++) begin
            e = frame_bit(8'h00, (i - 20) / 2);
            if (w2[i] !== e) bad++;
        end
        chk("div2_00_frame", bad, 0);
        bad = 0;
        for (int i = 40; i < 44; i++) if (w2[i] !== 1'b1) bad++;
        chk("div2_idle", bad, 0);
        wait_cycles(2);
        chk("div2_busy_off", busy2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
